// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply/divide datapath: data width,
// divider iteration-counter width and the divider control states.
package cpu_pkg;

    // Architectural data width of the integer datapath.
    localparam int DATA_W = 32;

    // Iteration counter width: must hold values 0..DATA_W.
    localparam int DIV_CNT_W = $clog2(DATA_W) + 1;

    // Divider control states.
    //   IDLE : waiting for start
    //   CALC : one restoring iteration per cycle
    //   FIX  : sign correction, load HI/LO
    //   ZERO : divide-by-zero completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_t;

endpackage : cpu_pkg

// File: rtl/seq_divider_div_step.sv
// Single restoring-division iteration, purely combinational.
// Shifts {rem, quo} left by one, then tries to subtract the divisor from the
// partial remainder; on success the difference is kept and a 1 enters the
// quotient LSB. Kept separate so a wider-radix divider can chain copies.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_abs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // Shifted remainder with an extra top bit so the subtraction's borrow
    // lands in a bit of its own and serves as the "trial < 0" flag.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Shift, trial-subtract, and restore when the trial went negative.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {2'b00, divisor_abs_i};
        rem_o   = shifted[WIDTH:0];
        quo_o   = {quo_i[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_o    = trial[WIDTH:0];
            quo_o[0] = 1'b1;
        end
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// Iterative signed divider for MIPS DIV: remainder to HI, quotient to LO.
// Works on magnitudes with a restoring algorithm (one bit per cycle) and
// fixes the signs at the end: the quotient truncates toward zero and the
// remainder takes the sign of the dividend. A zero divisor short-circuits
// to a one-cycle completion that raises div_zero and leaves HI/LO alone.
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Counter sized for this instance's width (0..WIDTH).
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // Two's-complement negation, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    // Magnitude as an unsigned value; the most negative number maps to
    // itself, which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg(v) : v;
    endfunction

    div_state_t       state_q,       state_d;
    logic [WIDTH:0]   rem_q,         rem_d;
    logic [WIDTH-1:0] quo_q,         quo_d;
    logic [WIDTH-1:0] divisor_abs_q, divisor_abs_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             sign_quo_q,    sign_quo_d;
    logic             sign_rem_q,    sign_rem_d;
    logic [WIDTH-1:0] hi_q,          hi_d;
    logic [WIDTH-1:0] lo_q,          lo_d;
    logic             done_q,        done_d;
    logic             div_zero_q,    div_zero_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i        (rem_q),
        .quo_i        (quo_q),
        .divisor_abs_i(divisor_abs_q),
        .rem_o        (step_rem),
        .quo_o        (step_quo)
    );

    // Control FSM register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration datapath: partial remainder, quotient shifter, operands, count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q         <= '0;
            quo_q         <= '0;
            divisor_abs_q <= '0;
            cnt_q         <= '0;
            sign_quo_q    <= 1'b0;
            sign_rem_q    <= 1'b0;
        end else begin
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            divisor_abs_q <= divisor_abs_d;
            cnt_q         <= cnt_d;
            sign_quo_q    <= sign_quo_d;
            sign_rem_q    <= sign_rem_d;
        end
    end

    // Result and status registers; HI/LO hold until the next completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state and datapath control; everything holds unless a state acts.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        divisor_abs_d = divisor_abs_q;
        cnt_d         = cnt_q;
        sign_quo_d    = sign_quo_q;
        sign_rem_d    = sign_rem_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_zero_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = ZERO;
                    end else begin
                        // Dividend magnitude is shifted into the remainder
                        // from the quotient register one bit per step.
                        quo_d         = magnitude(dividend);
                        divisor_abs_d = magnitude(divisor);
                        rem_d         = '0;
                        cnt_d         = '0;
                        sign_quo_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_rem_d    = dividend[WIDTH-1];
                        state_d       = CALC;
                    end
                end
            end

            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // The remainder magnitude is below the divisor magnitude, so
                // its low WIDTH bits carry the whole value.
                lo_d    = sign_quo_q ? neg(quo_q) : quo_q;
                hi_d    = sign_rem_q ? neg(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end

            ZERO: begin
                done_d     = 1'b1;
                div_zero_d = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule : seq_divider
